// File: rtl/systolic_result_deskew_acc.sv
// systolic_result_deskew_acc: realigns time-skewed systolic-array results and commits them into an accumulator buffer behind a valid/ready read port (optional macro ACC_SAT_EN: saturating accumulate plus sticky sat_o)
module systolic_result_deskew_acc #(
  parameter int N      = 32,
  parameter int ACC_W  = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              stall_i,
  input  logic              vec_valid_i,
  input  logic [ADDR_W-1:0] vec_addr_i,
  input  logic              vec_acc_i,
  input  logic [ACC_W-1:0]  array_data_i [N],
  output logic              busy_o,
  input  logic              rd_req_valid_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              rd_clear_i,
  output logic              rd_req_ready_o,
  output logic              rd_valid_o,
  output logic [ACC_W-1:0]  rd_data_o [N],
  input  logic              rd_ready_i
`ifdef ACC_SAT_EN
  ,
  output logic              sat_o
`endif
);
  typedef logic [N-1:0][ACC_W-1:0] vec_t;
  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] addr;
    logic              acc;
  } tag_t;
  tag_t              tag_q [N-1];
  tag_t              tag_d [N-1];
  vec_t              lane_a;
  vec_t              wval;
  vec_t              mem_q [DEPTH];
  vec_t              rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              commit, hit, rd_acc, clr, c_acc;
  logic [ADDR_W-1:0] c_addr;
`ifdef ACC_SAT_EN
  logic              sat_q, sat_d;
  logic [ACC_W:0]    sum;
`endif
  // Tag travels alongside lane 0 so it reaches the end exactly when lane N-1 arrives
  always_comb begin
    tag_d[0] = stall_i ? tag_q[0] : tag_t'{v: vec_valid_i, addr: vec_addr_i, acc: vec_acc_i};
    for (int j = 1; j < N-1; j++) tag_d[j] = stall_i ? tag_q[j] : tag_q[j-1];
  end
  // Something is in flight whenever any tag stage holds a valid vector
  always_comb begin
    busy_o = 1'b0;
    for (int j = 0; j < N-1; j++) busy_o = busy_o | tag_q[j].v;
  end
  // Lane k is delayed by N-1-k registers; the last lane is used straight off the array
  for (genvar k = 0; k < N-1; k++) begin : g_lane
    logic [ACC_W-1:0] sh_q [N-1-k];
    logic [ACC_W-1:0] sh_d [N-1-k];
    // Shift the lane's delay line only on non-stalled cycles
    always_comb begin
      sh_d[0] = stall_i ? sh_q[0] : array_data_i[k];
      for (int j = 1; j < N-1-k; j++) sh_d[j] = stall_i ? sh_q[j] : sh_q[j-1];
    end
    // Delay line storage, cleared so aborted vectors leave nothing behind
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) for (int j = 0; j < N-1-k; j++) sh_q[j] <= '0;
      else sh_q <= sh_d;
    end
    assign lane_a[k] = sh_q[N-2-k];
  end
  assign lane_a[N-1] = array_data_i[N-1];
  // Commit value: overwrite or add (wrapping, or clamped when saturation is built in)
  always_comb begin
    commit = tag_q[N-2].v && !stall_i;
    c_addr = tag_q[N-2].addr;
    c_acc  = tag_q[N-2].acc;
`ifdef ACC_SAT_EN
    sum   = '0;
    sat_d = sat_q;
`endif
    for (int k = 0; k < N; k++) begin
`ifdef ACC_SAT_EN
      sum     = {1'b0, mem_q[c_addr][k]} + {1'b0, lane_a[k]};
      wval[k] = !c_acc ? lane_a[k] : sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
      sat_d   = sat_d | (commit & c_acc & sum[ACC_W]);
`else
      wval[k] = c_acc ? mem_q[c_addr][k] + lane_a[k] : lane_a[k];
`endif
    end
  end
  // Read port; a same-edge commit to the read address is forwarded and wins over clear
  always_comb begin
    rd_req_ready_o = !rd_valid_q || rd_ready_i;
    rd_acc         = rd_req_valid_i && rd_req_ready_o;
    hit            = commit && (c_addr == rd_addr_i);
    rd_data_d      = rd_acc ? (hit ? wval : mem_q[rd_addr_i]) : rd_data_q;
    rd_valid_d     = rd_acc || (rd_valid_q && !rd_ready_i);
    clr            = rst_ni && rd_acc && rd_clear_i && !hit;
    for (int k = 0; k < N; k++) rd_data_o[k] = rd_data_q[k];
  end
  assign rd_valid_o = rd_valid_q;
`ifdef ACC_SAT_EN
  assign sat_o = sat_q;
`endif
  // Control and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int j = 0; j < N-1; j++) tag_q[j] <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
`ifdef ACC_SAT_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      tag_q      <= tag_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
`ifdef ACC_SAT_EN
      sat_q      <= sat_d;
`endif
    end
  end
  // Accumulator storage is deliberately not reset
  always_ff @(posedge clk_i) begin
    if (clr) mem_q[rd_addr_i] <= '0;
    if (commit) mem_q[c_addr] <= wval;
  end
endmodule
